// File: rtl/cardinal_pkg.sv
// Shared constants for the Cardinal NIC: CPU register addresses, VC bit position
// and the layout of the status words returned on the CPU read port.
// Data words use big-endian indexing [0:DW-1], so bit 0 is the MSB.
package cardinal_pkg;

   localparam logic [1:0] NIC_ADDR_IBUF = 2'b00;
   localparam logic [1:0] NIC_ADDR_ISTAT = 2'b01;
   localparam logic [1:0] NIC_ADDR_OBUF = 2'b10;
   localparam logic [1:0] NIC_ADDR_OSTAT = 2'b11;

   localparam int VC_BIT = 0;
   localparam int STATUS_FLAG_BIT = 63;
   localparam int STATUS_CNT_MSB = 48;
   localparam int STATUS_CNT_LSB = 55;
   localparam int STATUS_CNT_W = STATUS_CNT_LSB - STATUS_CNT_MSB + 1;

   // Pointer width; a single-entry FIFO still needs a 1-bit pointer to exist.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/cardinal_nic_if.sv
// Bus bundle between the NIC and its environment (CPU register port plus the
// router injection/ejection channels).
//   master : the environment side (CPU initiator and router)
//   slave  : the NIC
interface cardinal_nic_if #(
   parameter int DW = 64
);
   logic [1:0]    addr_nic;
   logic [0:DW-1] din_nic;
   logic [0:DW-1] dout_nic;
   logic          nicEn;
   logic          nicWrEn;
   logic          net_si;
   logic          net_ri;
   logic [0:DW-1] net_di;
   logic          net_so;
   logic          net_ro;
   logic [0:DW-1] net_do;
   logic          net_polarity;

   modport master (
      output addr_nic, din_nic, nicEn, nicWrEn,
      output net_si, net_di, net_ro, net_polarity,
      input  dout_nic, net_ri, net_so, net_do
   );

   modport slave (
      input  addr_nic, din_nic, nicEn, nicWrEn,
      input  net_si, net_di, net_ro, net_polarity,
      output dout_nic, net_ri, net_so, net_do
   );
endinterface

// File: rtl/cardinal_nic_fifo.sv
// DEPTH-entry FIFO used for both NIC directions.
// Ports: clk, reset (async, active-low), push/din, pop/dout, count, full, empty.
// dout shows the head entry and reads 0 while empty. A pop on empty is ignored;
// a push while full is taken only when a pop frees an entry on the same edge.
module cardinal_nic_fifo
   import cardinal_pkg::*;
#(
   parameter int DW    = 64,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [0:DW-1]          din,
   output logic [0:DW-1]          dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [0:DW-1] mem_q [DEPTH];
   logic [0:DW-1] mem_d [DEPTH];
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: bridges a CPU register port and the ring router.
// Ports: clk, reset (async, active-low), nic (cardinal_nic_if.slave) carrying
// the CPU port (addr_nic/din_nic/dout_nic/nicEn/nicWrEn) and the router
// channels (net_si/net_ri/net_di ejection, net_so/net_ro/net_do injection,
// net_polarity). All outputs are combinational from FIFO state and inputs.
module cardinal_nic
   import cardinal_pkg::*;
#(
   parameter int DW    = 64,
   parameter int DEPTH = 2
) (
   input logic           clk,
   input logic           reset,
   cardinal_nic_if.slave nic
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          rd_en, wr_en;
   logic          in_push, in_pop, in_full, in_empty;
   logic          out_push, out_pop, out_full, out_empty;
   logic [CW-1:0] in_count, out_count;
   logic [0:DW-1] in_head, out_head;
   logic [0:DW-1] in_status, out_status, dout;

   assign rd_en = nic.nicEn & ~nic.nicWrEn;
   assign wr_en = nic.nicEn & nic.nicWrEn;

   assign in_pop   = rd_en & (nic.addr_nic == NIC_ADDR_IBUF) & ~in_empty;
   assign out_push = wr_en & (nic.addr_nic == NIC_ADDR_OBUF);

   // Gating with reset keeps the router from handing over a packet that the
   // held-in-reset FIFO would drop.
   assign nic.net_ri = reset & ~in_full;
   assign in_push    = nic.net_si & nic.net_ri;

   // Only inject when the head packet's VC matches the router's current phase.
   assign nic.net_so = ~out_empty & nic.net_ro & (out_head[VC_BIT] == nic.net_polarity);
   assign out_pop    = nic.net_so;
   assign nic.net_do = out_head;

   always_comb begin
      in_status                                = '0;
      in_status[STATUS_FLAG_BIT]               = ~in_empty;
      in_status[STATUS_CNT_MSB:STATUS_CNT_LSB] = STATUS_CNT_W'(in_count);
      out_status                                = '0;
      out_status[STATUS_FLAG_BIT]               = out_full;
      out_status[STATUS_CNT_MSB:STATUS_CNT_LSB] = STATUS_CNT_W'(out_count);
   end

   always_comb begin
      dout = '0;
      if (rd_en) begin
         case (nic.addr_nic)
            NIC_ADDR_IBUF:  dout = in_head;
            NIC_ADDR_ISTAT: dout = in_status;
            NIC_ADDR_OSTAT: dout = out_status;
            default:        dout = '0;
         endcase
      end
   end

   assign nic.dout_nic = dout;

   cardinal_nic_fifo #(.DW(DW), .DEPTH(DEPTH)) in_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_push),
      .pop   (in_pop),
      .din   (nic.net_di),
      .dout  (in_head),
      .count (in_count),
      .full  (in_full),
      .empty (in_empty)
   );

   cardinal_nic_fifo #(.DW(DW), .DEPTH(DEPTH)) out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_push),
      .pop   (out_pop),
      .din   (nic.din_nic),
      .dout  (out_head),
      .count (out_count),
      .full  (out_full),
      .empty (out_empty)
   );

endmodule

// File: tb/tb_cardinal_nic.sv
// Bench for cardinal_nic: a queue-based model of the two buffers predicts every
// output on every cycle, and directed sequences add literal expectations.
module tb_cardinal_nic;
   import cardinal_pkg::*;

   localparam int DEPTH = 2;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_err    = 0;

   cardinal_nic_if #(.DW(64)) bus ();

   cardinal_nic #(.DW(64), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .nic   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- model ----------------
   logic [63:0] in_q[$];
   logic [63:0] out_q[$];

   function automatic logic [63:0] stat_word(input int flag, input int cnt);
      return 64'(flag) + (64'(cnt) << 8);
   endfunction

   function automatic logic [63:0] m_dout();
      logic [63:0] r;
      r = 64'h0;
      if (bus.nicEn && !bus.nicWrEn) begin
         case (bus.addr_nic)
            2'b00: r = (in_q.size() > 0) ? in_q[0] : 64'h0;
            2'b01: r = stat_word((in_q.size() > 0) ? 1 : 0, in_q.size());
            2'b11: r = stat_word((out_q.size() == DEPTH) ? 1 : 0, out_q.size());
            default: r = 64'h0;
         endcase
      end
      return r;
   endfunction

   function automatic logic m_ri();
      return reset && (in_q.size() < DEPTH);
   endfunction

   function automatic logic m_so();
      logic [63:0] h;
      if (out_q.size() == 0) return 1'b0;
      h = out_q[0];
      return bus.net_ro && (h[63] == bus.net_polarity);
   endfunction

   logic       m_in_push, m_in_pop, m_out_push, m_out_pop;
   logic [63:0] m_wdata, m_edata;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_q.delete();
         out_q.delete();
      end else begin
         m_in_pop   = bus.nicEn && !bus.nicWrEn && bus.addr_nic == 2'b00 && in_q.size() > 0;
         m_in_push  = bus.net_si && m_ri();
         m_out_pop  = m_so();
         m_out_push = bus.nicEn && bus.nicWrEn && bus.addr_nic == 2'b10 &&
                      (out_q.size() < DEPTH || m_out_pop);
         m_wdata    = bus.din_nic;
         m_edata    = bus.net_di;
         if (m_in_pop)   void'(in_q.pop_front());
         if (m_out_pop)  void'(out_q.pop_front());
         if (m_in_push)  in_q.push_back(m_edata);
         if (m_out_push) out_q.push_back(m_wdata);
      end
   end

   always @(negedge clk) begin
      check("model_dout", bus.dout_nic, m_dout());
      check("model_net_ri", 64'(bus.net_ri), 64'(m_ri()));
      check("model_net_so", 64'(bus.net_so), 64'(m_so()));
      if (out_q.size() > 0) check("model_net_do", bus.net_do, out_q[0]);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.nicEn   = 1'b0;
      bus.nicWrEn = 1'b0;
      bus.addr_nic = 2'b00;
      bus.din_nic  = '0;
   endtask

   task automatic cpu_wr(input logic [1:0] a, input logic [63:0] d);
      bus.nicEn    = 1'b1;
      bus.nicWrEn  = 1'b1;
      bus.addr_nic = a;
      bus.din_nic  = d;
   endtask

   task automatic cpu_rd(input logic [1:0] a);
      bus.nicEn    = 1'b1;
      bus.nicWrEn  = 1'b0;
      bus.addr_nic = a;
      bus.din_nic  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b0;
      idle();
      bus.net_si       = 1'b0;
      bus.net_di       = '0;
      bus.net_ro       = 1'b0;
      bus.net_polarity = 1'b0;

      // 1: reset
      repeat (2) @(posedge clk);
      #1;
      check("ri_in_reset", 64'(bus.net_ri), 64'h0);
      reset = 1'b1;
      #1;
      check("rst_ri", 64'(bus.net_ri), 64'h1);
      check("rst_so", 64'(bus.net_so), 64'h0);
      check("rst_do", bus.net_do, 64'h0);
      check("rst_dout", bus.dout_nic, 64'h0);
      cpu_rd(NIC_ADDR_ISTAT); #1;
      check("rst_istat", bus.dout_nic, 64'h0);
      cpu_rd(NIC_ADDR_OSTAT); #1;
      check("rst_ostat", bus.dout_nic, 64'h0);
      tick(); idle();

      // 2: single injection
      bus.net_polarity = 1'b0;
      bus.net_ro       = 1'b1;
      cpu_wr(NIC_ADDR_OBUF, 64'h0000_0000_0000_00AA);
      tick(); idle(); #1;
      check("inj_so", 64'(bus.net_so), 64'h1);
      check("inj_do", bus.net_do, 64'h0000_0000_0000_00AA);
      tick(); #1;
      check("inj_so_after", 64'(bus.net_so), 64'h0);

      // 3: out-FIFO full, third write dropped
      bus.net_ro = 1'b0;
      cpu_wr(NIC_ADDR_OBUF, 64'hA); tick();
      cpu_wr(NIC_ADDR_OBUF, 64'hB); tick();
      cpu_wr(NIC_ADDR_OBUF, 64'hC); tick();
      cpu_rd(NIC_ADDR_OSTAT); #1;
      check("full_ostat", bus.dout_nic, 64'h0000_0000_0000_0201);
      idle();
      bus.net_ro = 1'b1; #1;
      check("drain_a_so", 64'(bus.net_so), 64'h1);
      check("drain_a", bus.net_do, 64'hA);
      tick(); #1;
      check("drain_b_so", 64'(bus.net_so), 64'h1);
      check("drain_b", bus.net_do, 64'hB);
      tick(); #1;
      check("drain_done_so", 64'(bus.net_so), 64'h0);
      cpu_rd(NIC_ADDR_OSTAT); #1;
      check("drain_ostat", bus.dout_nic, 64'h0);
      tick(); idle();

      // 7: write while full accepted when the same edge pops
      bus.net_ro = 1'b0;
      cpu_wr(NIC_ADDR_OBUF, 64'hD); tick();
      cpu_wr(NIC_ADDR_OBUF, 64'hE); tick();
      cpu_wr(NIC_ADDR_OBUF, 64'hF);
      bus.net_ro = 1'b1; #1;
      check("fullpp_do_d", bus.net_do, 64'hD);
      tick();
      cpu_rd(NIC_ADDR_OSTAT); #1;
      check("fullpp_ostat", bus.dout_nic, 64'h0000_0000_0000_0201);
      check("fullpp_do_e", bus.net_do, 64'hE);
      tick(); idle(); #1;
      check("fullpp_do_f", bus.net_do, 64'hF);
      tick(); #1;
      check("fullpp_empty_so", 64'(bus.net_so), 64'h0);

      // 4: polarity gate
      bus.net_polarity = 1'b0;
      cpu_wr(NIC_ADDR_OBUF, 64'h8000_0000_0000_0001);
      tick(); idle(); #1;
      check("pol_block1", 64'(bus.net_so), 64'h0);
      tick(); #1;
      check("pol_block2", 64'(bus.net_so), 64'h0);
      bus.net_polarity = 1'b1; #1;
      check("pol_pass_so", 64'(bus.net_so), 64'h1);
      check("pol_pass_do", bus.net_do, 64'h8000_0000_0000_0001);
      tick(); #1;
      check("pol_after", 64'(bus.net_so), 64'h0);
      bus.net_polarity = 1'b0;

      // 5: ejection
      bus.net_si = 1'b1;
      bus.net_di = 64'h1234; #1;
      check("ej_ri0", 64'(bus.net_ri), 64'h1);
      tick(); #1;
      check("ej_ri1", 64'(bus.net_ri), 64'h1);
      tick(); #1;
      check("ej_ri_full", 64'(bus.net_ri), 64'h0);
      tick();
      bus.net_si = 1'b0;
      bus.net_di = '0;
      cpu_rd(NIC_ADDR_ISTAT); #1;
      check("ej_istat2", bus.dout_nic, 64'h0000_0000_0000_0201);
      tick();
      cpu_rd(NIC_ADDR_IBUF); #1;
      check("ej_head", bus.dout_nic, 64'h1234);
      tick();
      cpu_rd(NIC_ADDR_ISTAT); #1;
      check("ej_istat1", bus.dout_nic, 64'h0000_0000_0000_0101);
      check("ej_ri_back", 64'(bus.net_ri), 64'h1);
      tick();
      cpu_rd(NIC_ADDR_IBUF); #1;
      check("ej_head2", bus.dout_nic, 64'h1234);
      tick();
      cpu_rd(NIC_ADDR_IBUF); #1;
      check("ej_empty_read", bus.dout_nic, 64'h0);
      tick(); idle();

      // 6: reset with one entry in each FIFO
      bus.net_si = 1'b1;
      bus.net_di = 64'h5555;
      tick();
      bus.net_si = 1'b0;
      bus.net_ro = 1'b0;
      cpu_wr(NIC_ADDR_OBUF, 64'h77);
      tick();
      cpu_rd(NIC_ADDR_ISTAT); #1;
      check("pre_rst_istat", bus.dout_nic, 64'h0000_0000_0000_0101);
      reset = 1'b0;
      bus.net_ro = 1'b1; #1;
      check("mid_rst_so", 64'(bus.net_so), 64'h0);
      check("mid_rst_ri", 64'(bus.net_ri), 64'h0);
      check("mid_rst_istat", bus.dout_nic, 64'h0);
      cpu_rd(NIC_ADDR_OSTAT); #1;
      check("mid_rst_ostat", bus.dout_nic, 64'h0);
      tick(); tick();
      reset = 1'b1;
      cpu_rd(NIC_ADDR_ISTAT); #1;
      check("post_rst_ri", 64'(bus.net_ri), 64'h1);
      check("post_rst_istat", bus.dout_nic, 64'h0);
      check("post_rst_so", 64'(bus.net_so), 64'h0);
      cpu_rd(NIC_ADDR_OSTAT); #1;
      check("post_rst_ostat", bus.dout_nic, 64'h0);
      tick(); idle();
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
